// File: rtl/hazard_pkg.sv
// Shared types and helpers for the load-use hazard detection unit.
package hazard_pkg;

    localparam int              HZ_REG_W = 5;
    localparam logic [HZ_REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                valid;
        logic [HZ_REG_W-1:0] dest;
    } ld_shadow_t;

    // True when the ID instruction reads the register a tracked load will write.
    function automatic logic src_match(
        input logic [HZ_REG_W-1:0] rs,
        input logic                rs_used,
        input logic [HZ_REG_W-1:0] rt,
        input logic                rt_used,
        input ld_shadow_t          entry
    );
        return entry.valid && (entry.dest != REG_ZERO) &&
               ((rs_used && (rs == entry.dest)) || (rt_used && (rt == entry.dest)));
    endfunction

endpackage

// File: rtl/hazard_shadow_stage.sv
// One shadow register tracking the load occupying a pipeline stage.
module hazard_shadow_stage
    import hazard_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  ld_shadow_t d_i,
    output ld_shadow_t q_o
);

    ld_shadow_t entry_q, entry_d;

    // The pipeline advances every cycle, so the entry either follows its
    // source or is emptied when a bubble or flush enters the stage.
    always_comb begin
        entry_d = d_i;
        if (clr_i) entry_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) entry_q <= '0;
        else        entry_q <= entry_d;
    end

    assign q_o = entry_q;

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use hazard detection: stall/bubble/flush control and stall counter.
module hazard_detection_unit
    import hazard_pkg::*;
#(
    parameter int LOAD_LAT    = 1,
    parameter int REG_W       = HZ_REG_W,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   id_valid_i,
    input  logic [REG_W-1:0]       id_rs_i,
    input  logic [REG_W-1:0]       id_rt_i,
    input  logic                   id_rs_used_i,
    input  logic                   id_rt_used_i,
    input  logic                   id_mem_read_i,
    input  logic                   id_reg_write_i,
    input  logic [REG_W-1:0]       id_wr_reg_i,
    input  logic                   branch_taken_i,
    output logic                   pc_control,
    output logic                   ifid_hold_o,
    output logic                   idex_bubble_o,
    output logic                   ifid_flush_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    ld_shadow_t ex_ld, mem_ld, ex_ld_in;
    logic       hz_ex, hz_mem, stall;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

    assign ex_ld_in = '{valid: id_valid_i & id_mem_read_i & id_reg_write_i,
                        dest:  id_wr_reg_i};

    hazard_shadow_stage u_ex_shadow (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (branch_taken_i | stall),
        .d_i   (ex_ld_in),
        .q_o   (ex_ld)
    );

    hazard_shadow_stage u_mem_shadow (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (branch_taken_i),
        .d_i   (ex_ld),
        .q_o   (mem_ld)
    );

    assign hz_ex = src_match(id_rs_i, id_rs_used_i, id_rt_i, id_rt_used_i, ex_ld);

    // Without MEM->EX forwarding a load still in MEM is too late as well.
    generate
        if (LOAD_LAT == 2) begin : g_mem_hz
            assign hz_mem = src_match(id_rs_i, id_rs_used_i, id_rt_i, id_rt_used_i, mem_ld);
        end else begin : g_no_mem_hz
            assign hz_mem = 1'b0;
        end
    endgenerate

    assign stall         = id_valid_i & (hz_ex | hz_mem) & ~branch_taken_i;
    assign pc_control    = stall;
    assign ifid_hold_o   = stall;
    assign idex_bubble_o = stall | branch_taken_i;
    assign ifid_flush_o  = branch_taken_i;

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != {STALL_CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign stall_cnt_o = cnt_q;

endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
Generates the pipeline hold/flush controls for the 5-stage MIPS core, including pc_control, the hold input of the ProgramCounter. It keeps its own shadow of the load destinations in EX and MEM and compares them with the source registers of the instruction in ID. It detects load-use hazards, inserts one or two bubbles depending on the forwarding configuration, gives priority to taken-branch flushes, and counts stall cycles.

Parameters:
LOAD_LAT, 1, bubbles needed after a load: 1 = MEM->EX forwarding present, 2 = no MEM forwarding, so a MEM-stage load also hazards.
REG_W, 5, register index width.
STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous, active-low reset.
id_valid_i  in  1  IF/ID holds a real instruction (0 = bubble).
id_rs_i  in  REG_W  rs field of the ID instruction.
id_rt_i  in  REG_W  rt field of the ID instruction.
id_rs_used_i  in  1  ID instruction reads rs.
id_rt_used_i  in  1  ID instruction reads rt.
id_mem_read_i  in  1  ID instruction is a load.
id_reg_write_i  in  1  ID instruction writes the register file.
id_wr_reg_i  in  REG_W  ID destination register (post RegDst mux).
branch_taken_i  in  1  taken branch/jump resolved this cycle; flush the younger stages.
pc_control  out  1  1 = PC holds its value; 0 = PC loads the next value.
ifid_hold_o  out  1  1 = IF/ID register keeps its contents.
idex_bubble_o  out  1  1 = ID/EX loads a NOP (control bits zeroed).
ifid_flush_o  out  1  1 = IF/ID loads a NOP.
stall_cnt_o  out  STALL_CNT_W  number of load-use stall cycles since reset, saturating.

Behaviour:
- Reset (rst_i=0, asynchronous): ex_ld and mem_ld valid bits clear, destinations 0, stall_cnt_o=0. With shadows clear, all control outputs are 0.
- Shadow entries hold a valid bit and a destination. ex_ld describes the load now in EX; mem_ld describes the load now in MEM.
- Load-use hazard (combinational, same cycle as ID presents the instruction):
  - hz_ex = ex_ld.valid and dest!=0 and ((id_rs_used_i and id_rs_i==dest) or (id_rt_used_i and id_rt_i==dest)).
  - hz_mem: same comparison against mem_ld; contributes only when LOAD_LAT==2.
  - stall = id_valid_i and (hz_ex or hz_mem) and not branch_taken_i.
- Outputs (combinational):
  - pc_control = ifid_hold_o = stall.
  - idex_bubble_o = stall or branch_taken_i.
  - ifid_flush_o = branch_taken_i.
- Register $0 never causes a hazard, whether as a destination or as a source.
- Shadow update on each rising edge:
  - branch_taken_i=1: ex_ld and mem_ld are both cleared, because the flushed instructions never commit.
  - stall=1: ex_ld is cleared (a bubble enters EX); mem_ld <= ex_ld.
  - Otherwise: ex_ld.valid <= id_valid_i and id_mem_read_i and id_reg_write_i, ex_ld.dest <= id_wr_reg_i; mem_ld <= ex_ld.
- Stall duration: 1 cycle per dependent load when LOAD_LAT=1. When LOAD_LAT=2, the stall lasts 2 cycles if the consumer immediately follows the load, and 1 cycle if one instruction separates them.
- No deadlock: a stall always drains the matching entry within LOAD_LAT cycles.
- Counter: stall_cnt_o increments by 1 on each edge where stall=1 and holds at all-ones. Branch-flush cycles are not counted.
- Simultaneous branch_taken_i and a hazard: the flush wins. pc_control=0 so the PC loads the branch target, and no stall is counted.
- Reset asserted mid-stall: the shadows clear immediately, and pc_control drops to 0 in the same cycle, without waiting for a clock edge.

Decomposition:
- Package hazard_pkg holds:
  - REG_ZERO (5'd0).
  - The struct/typedef ld_shadow_t = {valid, dest[REG_W-1:0]}.
  - The function src_match(rs, rs_used, rt, rt_used, entry).
- One natural sub-module is hazard_shadow_stage: a single shadow register with clear/load/shift controls and asynchronous reset. Instantiate it twice, once for EX and once for MEM.
- The counter and the comparison logic stay in the top-level module.

Test Plan:
1. LOAD_LAT=1: lw $2 in ID at cycle n, then add $3,$2,$4 in ID at n+1 -> pc_control=ifid_hold_o=idex_bubble_o=1 for exactly cycle n+1 and 0 at n+2; stall_cnt_o goes 0->1.
2. LOAD_LAT=2, same sequence -> stall held for cycles n+1 and n+2, released at n+3; stall_cnt_o=2. Separately, with a nop between lw and the consumer -> exactly 1 stall cycle.
3. lw $0 followed by add $3,$0,$0, and lw $5 followed by a consumer with id_rs_used_i=0 and id_rt_used_i=0 on rs=5 -> no stall; stall_cnt_o stays 0.
4. Hazard present while branch_taken_i=1 -> pc_control=0, ifid_flush_o=1, idex_bubble_o=1; next cycle the shadows are empty, so a consumer of the old load does not stall; counter unchanged.
5. Assert rst_i=0 asynchronously (between clock edges) during a stall cycle -> pc_control, ifid_hold_o and idex_bubble_o go to 0 before the next edge; stall_cnt_o=0.
6. STALL_CNT_W=4, 20 back-to-back load-use pairs -> stall_cnt_o saturates at 15 and stays there.
